imm_extend_unit: RTL and testbench

- Parametrised, pipelined immediate-extension stage: the next generation of the fixed 8-to-16 zero extender.
- Widens an IN_W-bit immediate to OUT_W bits in one of four modes:
  - zero-extend
  - sign-extend
  - shift-to-upper
  - prefix-concatenate, using an upper-bits prefix latched by an earlier prefix instruction
- Sits between decode and the ALU operand mux; valid/ready handshake on both sides, one registered output slot.

---
 rtl/imm_extend_unit.sv | 108 ++++++++++
 tb/tb_imm_extend_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_unit.sv
// Pipelined immediate extender: widens an IN_W immediate to OUT_W bits (zero/sign/upper/prefix-concat)
// behind a single registered output slot with valid/ready handshakes on both sides.
module imm_extend_unit #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int PFX_W = OUT_W - IN_W
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic             pfx_load,
  input  logic [PFX_W-1:0] pfx_data,
  output logic             pfx_pending,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_result,
  output logic             out_nopfx
);

  localparam logic [1:0] MODE_ZERO   = 2'b00;
  localparam logic [1:0] MODE_SIGN   = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;
  localparam logic [1:0] MODE_CONCAT = 2'b11;

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_result_q, out_result_d;
  logic             out_nopfx_q, out_nopfx_d;
  logic [PFX_W-1:0] pfx_q, pfx_d;
  logic             pfx_pend_q, pfx_pend_d;

  logic             accept;
  logic [OUT_W-1:0] ext_result;
  logic             ext_nopfx;

  // The slot can take a new request whenever it is empty or being drained this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    ext_result = {{PFX_W{1'b0}}, in_imm};
    ext_nopfx  = 1'b0;
    case (in_mode)
      MODE_ZERO:  ext_result = {{PFX_W{1'b0}}, in_imm};
      MODE_SIGN:  ext_result = {{PFX_W{in_imm[IN_W-1]}}, in_imm};
      MODE_UPPER: ext_result = {in_imm, {PFX_W{1'b0}}};
      MODE_CONCAT: begin
        // Without a pending prefix, fall back to zero-extension and flag it.
        if (pfx_pend_q) begin
          ext_result = {pfx_q, in_imm};
        end else begin
          ext_result = {{PFX_W{1'b0}}, in_imm};
          ext_nopfx  = 1'b1;
        end
      end
      default: ext_result = {{PFX_W{1'b0}}, in_imm};
    endcase
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_nopfx_d  = out_nopfx_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_result_d = ext_result;
      out_nopfx_d  = ext_nopfx;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // A fresh load wins over consumption so a same-cycle load is never lost.
  always_comb begin
    pfx_d      = pfx_q;
    pfx_pend_d = pfx_pend_q;
    if (pfx_load) begin
      pfx_d      = pfx_data;
      pfx_pend_d = 1'b1;
    end else if (accept && (in_mode == MODE_CONCAT)) begin
      pfx_pend_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_nopfx_q  <= 1'b0;
      pfx_q        <= '0;
      pfx_pend_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_nopfx_q  <= out_nopfx_d;
      pfx_q        <= pfx_d;
      pfx_pend_q   <= pfx_pend_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_nopfx   = out_nopfx_q;
  assign pfx_pending = pfx_pend_q;

endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed scoreboard bench for imm_extend_unit: default 8->16 instance plus a 4->12 instance.
module tb_imm_extend_unit;

  typedef struct packed {
    logic [15:0] res;
    logic        nopfx;
  } exp_t;

  logic        CLK;
  logic        Reset;

  logic        a_in_valid, a_in_ready, a_pfx_load, a_pfx_pending;
  logic        a_out_valid, a_out_ready, a_out_nopfx;
  logic [7:0]  a_in_imm, a_pfx_data;
  logic [1:0]  a_in_mode;
  logic [15:0] a_out_result;

  logic        b_in_valid, b_in_ready, b_pfx_load, b_pfx_pending;
  logic        b_out_valid, b_out_ready, b_out_nopfx;
  logic [3:0]  b_in_imm;
  logic [7:0]  b_pfx_data;
  logic [1:0]  b_in_mode;
  logic [11:0] b_out_result;

  exp_t sbq[$];
  exp_t sbq4[$];
  int   n_asrt = 0;
  int   n_fail = 0;

  imm_extend_unit #(.IN_W(8), .OUT_W(16)) u_a (
    .CLK(CLK), .Reset(Reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_imm(a_in_imm), .in_mode(a_in_mode),
    .pfx_load(a_pfx_load), .pfx_data(a_pfx_data), .pfx_pending(a_pfx_pending),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_result(a_out_result),
    .out_nopfx(a_out_nopfx)
  );

  imm_extend_unit #(.IN_W(4), .OUT_W(12)) u_b (
    .CLK(CLK), .Reset(Reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_imm(b_in_imm), .in_mode(b_in_mode),
    .pfx_load(b_pfx_load), .pfx_data(b_pfx_data), .pfx_pending(b_pfx_pending),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_out_result),
    .out_nopfx(b_out_nopfx)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] res, input logic nopfx);
    sbq.push_back('{res: res, nopfx: nopfx});
  endtask

  task automatic push4(input logic [15:0] res, input logic nopfx);
    sbq4.push_back('{res: res, nopfx: nopfx});
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, ".valid"}, 32'(a_out_valid), 32'd1);
    chk({tag, ".sbq"}, 32'(sbq.size() > 0), 32'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, ".result"}, 32'(a_out_result), 32'(e.res));
      chk({tag, ".nopfx"}, 32'(a_out_nopfx), 32'(e.nopfx));
    end
  endtask

  task automatic pop_check4(input string tag);
    exp_t e;
    chk({tag, ".valid"}, 32'(b_out_valid), 32'd1);
    chk({tag, ".sbq"}, 32'(sbq4.size() > 0), 32'd1);
    if (sbq4.size() > 0) begin
      e = sbq4.pop_front();
      chk({tag, ".result"}, 32'(b_out_result), 32'(e.res));
      chk({tag, ".nopfx"}, 32'(b_out_nopfx), 32'(e.nopfx));
    end
  endtask

  initial begin
    Reset = 1'b1;
    a_in_valid = 0; a_in_imm = '0; a_in_mode = '0; a_pfx_load = 0; a_pfx_data = '0; a_out_ready = 0;
    b_in_valid = 0; b_in_imm = '0; b_in_mode = '0; b_pfx_load = 0; b_pfx_data = '0; b_out_ready = 0;
    tick();
    tick();
    Reset = 1'b0;
    chk("rst.valid", 32'(a_out_valid), 32'd0);
    chk("rst.result", 32'(a_out_result), 32'd0);
    chk("rst.nopfx", 32'(a_out_nopfx), 32'd0);
    chk("rst.pending", 32'(a_pfx_pending), 32'd0);
    a_out_ready = 1'b1;
    #1;
    chk("rst.in_ready", 32'(a_in_ready), 32'd1);

    // All four modes back to back, no prefix loaded
    a_in_valid = 1'b1; a_in_imm = 8'hA5;
    a_in_mode = 2'b00; push(16'h00A5, 1'b0); tick(); pop_check("mode_zero");
    a_in_mode = 2'b01; push(16'hFFA5, 1'b0); tick(); pop_check("mode_sign");
    a_in_mode = 2'b10; push(16'hA500, 1'b0); tick(); pop_check("mode_upper");
    a_in_mode = 2'b11; push(16'h00A5, 1'b1); tick(); pop_check("mode_concat_nopfx");
    a_in_valid = 1'b0;
    tick();
    chk("idle.valid", 32'(a_out_valid), 32'd0);
    chk("idle.result_kept", 32'(a_out_result), 32'h00A5);

    // Prefix load then two CONCATs; the prefix is consumed only once
    a_pfx_load = 1'b1; a_pfx_data = 8'h12;
    tick();
    a_pfx_load = 1'b0;
    chk("pfx.pending_set", 32'(a_pfx_pending), 32'd1);
    a_in_valid = 1'b1; a_in_mode = 2'b11; a_in_imm = 8'h34;
    push(16'h1234, 1'b0); tick(); pop_check("concat_pfx");
    chk("pfx.pending_clr", 32'(a_pfx_pending), 32'd0);
    push(16'h0034, 1'b1); tick(); pop_check("concat_again");

    // Backpressure: held result stays put and the new request waits
    a_in_mode = 2'b00; a_in_imm = 8'h55; a_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall.in_ready", 32'(a_in_ready), 32'd0);
      tick();
      chk("stall.valid", 32'(a_out_valid), 32'd1);
      chk("stall.result", 32'(a_out_result), 32'h0034);
    end
    a_out_ready = 1'b1;
    #1;
    chk("release.in_ready", 32'(a_in_ready), 32'd1);
    push(16'h0055, 1'b0); tick(); pop_check("drain_accept");
    a_in_valid = 1'b0;

    // Load and consume in the same cycle
    a_pfx_load = 1'b1; a_pfx_data = 8'hAA;
    tick();
    a_pfx_data = 8'hBB;
    a_in_valid = 1'b1; a_in_mode = 2'b11; a_in_imm = 8'h01;
    push(16'hAA01, 1'b0); tick();
    a_pfx_load = 1'b0;
    pop_check("simul_old_pfx");
    chk("simul.pending", 32'(a_pfx_pending), 32'd1);
    a_in_imm = 8'h02;
    push(16'hBB02, 1'b0); tick(); pop_check("simul_new_pfx");
    chk("simul.pending_clr", 32'(a_pfx_pending), 32'd0);

    // Prefix loaded while a CONCAT is stalled is seen at acceptance
    a_out_ready = 1'b0; a_in_imm = 8'h03; a_pfx_load = 1'b1; a_pfx_data = 8'hCC;
    #1;
    chk("stallpfx.in_ready", 32'(a_in_ready), 32'd0);
    tick();
    a_pfx_load = 1'b0;
    chk("stallpfx.pending", 32'(a_pfx_pending), 32'd1);
    chk("stallpfx.held", 32'(a_out_result), 32'hBB02);
    a_out_ready = 1'b1;
    push(16'hCC03, 1'b0); tick(); pop_check("stallpfx_accept");
    chk("stallpfx.pending_clr", 32'(a_pfx_pending), 32'd0);
    a_in_valid = 1'b0;

    // Reset with a held result and a pending prefix
    a_out_ready = 1'b0; a_pfx_load = 1'b1; a_pfx_data = 8'h77;
    tick();
    a_pfx_load = 1'b0;
    chk("prerst.valid", 32'(a_out_valid), 32'd1);
    chk("prerst.pending", 32'(a_pfx_pending), 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("midrst.valid", 32'(a_out_valid), 32'd0);
    chk("midrst.result", 32'(a_out_result), 32'd0);
    chk("midrst.pending", 32'(a_pfx_pending), 32'd0);
    chk("midrst.nopfx", 32'(a_out_nopfx), 32'd0);
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_in_mode = 2'b11; a_in_imm = 8'h7F;
    push(16'h007F, 1'b1); tick(); pop_check("postrst_concat");
    a_in_valid = 1'b0;
    tick();

    // Narrow instance: SIGN/UPPER then 8 back-to-back accepts
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_imm = 4'h8;
    b_in_mode = 2'b01; push4(16'h0FF8, 1'b0); tick(); pop_check4("w4_sign");
    b_in_mode = 2'b10; push4(16'h0800, 1'b0); tick(); pop_check4("w4_upper");
    b_in_mode = 2'b00;
    for (int i = 0; i < 8; i++) begin
      b_in_imm = 4'(i);
      push4(16'(i), 1'b0);
      tick();
      pop_check4("w4_stream");
    end
    b_in_valid = 1'b0;
    tick();
    chk("w4.drained", 32'(b_out_valid), 32'd0);
    chk("sbq.empty", 32'(sbq.size() + sbq4.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
